// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the issue logic (master) and alu_share_arbiter (slave).
interface alu_share_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req1_a;
  logic [31:0] req0_b, req1_b;
  logic [4:0]  req0_op, req1_op;
  logic        req0_cin, req1_cin;
  logic [1:0]  req_use_cf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [1:0]  cf_q;

  modport master (
    output req_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
           req0_cin, req1_cin, req_use_cf, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, cf_q
  );

  modport slave (
    input  req_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
           req0_cin, req1_cin, req_use_cf, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, cf_q
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU, with per-requester
// saved carry and a single registered response slot. Optional opcode check: ALU_ARB_OPCHK_EN.

// Opcodes: 0 ADD 1 ADC 2 SUB 3 SBB 4 AND 5 OR 6 XOR 7 NOT 8 SHL 9 SHR 10 SAR
// 11 ROL 12 ROR 13 RCL 14 RCR; anything else yields 0. Flags = {V,C,N,Z}.
module alu_advanced (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  op_i,
  input  logic        cin_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);
  logic [5:0]  sh;
  logic        is_sub, ci, c, v;
  logic [31:0] bb, res;
  logic [32:0] sum, rc_x, rc_l, rc_r;

  always_comb begin
    sh     = {1'b0, b_i[4:0]};
    is_sub = (op_i == 5'd2) || (op_i == 5'd3);
    bb     = is_sub ? ~b_i : b_i;
    case (op_i)
      5'd1:    ci = cin_i;
      5'd2:    ci = 1'b1;
      5'd3:    ci = ~cin_i;
      default: ci = 1'b0;
    endcase
    sum  = {1'b0, a_i} + {1'b0, bb} + {32'd0, ci};
    // Rotate-through-carry treats {C,A} as one 33-bit ring.
    rc_x = {cin_i, a_i};
    rc_l = (rc_x << sh) | (rc_x >> (6'd33 - sh));
    rc_r = (rc_x >> sh) | (rc_x << (6'd33 - sh));
    res  = 32'd0;
    c    = 1'b0;
    v    = 1'b0;
    case (op_i)
      5'd0, 5'd1, 5'd2, 5'd3: begin
        res = sum[31:0];
        c   = is_sub ? ~sum[32] : sum[32];
        v   = (a_i[31] == bb[31]) && (sum[31] != a_i[31]);
      end
      5'd4:  res = a_i & b_i;
      5'd5:  res = a_i | b_i;
      5'd6:  res = a_i ^ b_i;
      5'd7:  res = ~a_i;
      5'd8:  res = a_i << sh;
      5'd9:  res = a_i >> sh;
      5'd10: res = $signed(a_i) >>> sh;
      5'd11: begin res = (a_i << sh) | (a_i >> (6'd32 - sh)); c = res[0];  end
      5'd12: begin res = (a_i >> sh) | (a_i << (6'd32 - sh)); c = res[31]; end
      5'd13: begin res = rc_l[31:0]; c = rc_l[32]; end
      5'd14: begin res = rc_r[31:0]; c = rc_r[32]; end
      default: res = 32'd0;
    endcase
    result_o = res;
    flags_o  = {v, c, res[31], (res == 32'd0)};
  end
endmodule

module alu_share_arbiter #(
  parameter logic [4:0] LEGAL_OP_MAX = 5'd14,
  parameter logic       CF_RESET     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  cf_q, cf_d;
  logic        rr_q, rr_d;

  logic        can_accept, gid, xfer, op_err;
  logic [1:0]  grant;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  alu_op;
  logic        alu_cin;
  logic [3:0]  alu_flg;

  always_comb begin
    grant = 2'b00;
    if (bus.req_valid == 2'b11) grant[rr_q] = 1'b1;
    else                        grant = bus.req_valid;
  end

  // rst_n gates ready so nothing handshakes while the slot is held in reset.
  assign can_accept    = !rsp_valid_q || bus.rsp_ready;
  assign bus.req_ready = {2{can_accept & rst_n}} & grant;
  assign gid           = grant[1];
  assign xfer          = |bus.req_ready;

  assign alu_a   = gid ? bus.req1_a  : bus.req0_a;
  assign alu_b   = gid ? bus.req1_b  : bus.req0_b;
  assign alu_op  = gid ? bus.req1_op : bus.req0_op;
  assign alu_cin = bus.req_use_cf[gid] ? cf_q[gid] : (gid ? bus.req1_cin : bus.req0_cin);

  alu_advanced u_alu (
    .a_i(alu_a), .b_i(alu_b), .op_i(alu_op), .cin_i(alu_cin),
    .result_o(alu_res), .flags_o(alu_flg)
  );

`ifdef ALU_ARB_OPCHK_EN
  assign op_err = (alu_op > LEGAL_OP_MAX);
`else
  logic unused_opmax;
  assign unused_opmax = ^LEGAL_OP_MAX;
  assign op_err       = 1'b0;
`endif

  // Each carry is touched only by its own requester's legal transfers.
  for (genvar i = 0; i < 2; i++) begin : g_cf
    assign cf_d[i] = (xfer && gid == 1'(i) && !op_err) ? alu_flg[2] : cf_q[i];
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    rr_d         = rr_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gid;
      rsp_result_d = op_err ? 32'd0 : alu_res;
      rsp_flags_d  = op_err ? 4'd0  : alu_flg;
      rsp_err_d    = op_err;
      rr_d         = ~gid;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 4'd0;
      rsp_err_q    <= 1'b0;
      cf_q         <= {CF_RESET, CF_RESET};
      rr_q         <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      cf_q         <= cf_d;
      rr_q         <= rr_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.cf_q       = cf_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus();
  alu_share_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  bit        m_rv, m_id, m_err, m_rr;
  bit [31:0] m_res;
  bit [3:0]  m_flg;
  bit [1:0]  m_cf;
  bit [1:0]  m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void alu_ref(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b,
                                  input bit cin, output bit [31:0] r, output bit [3:0] f,
                                  output bit err);
    bit c = 1'b0, v = 1'b0, t;
    int n = int'(b[4:0]);
    err = 1'b0;
    r   = 32'd0;
`ifdef ALU_ARB_OPCHK_EN
    if (op > 5'd14) begin err = 1'b1; f = 4'd0; return; end
`endif
    case (op)
      5'd0: begin {c, r} = {1'b0, a} + {1'b0, b};       v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1: begin {c, r} = {1'b0, a} + {1'b0, b} + 33'(cin); v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd2: begin r = a - b;       c = (a < b);                              v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd3: begin r = a - b - 32'(cin); c = ({1'b0, a} < {1'b0, b} + 33'(cin)); v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd4: r = a & b;
      5'd5: r = a | b;
      5'd6: r = a ^ b;
      5'd7: r = ~a;
      5'd8: r = a << n;
      5'd9: r = a >> n;
      5'd10: r = $signed(a) >>> n;
      5'd11: begin r = a; for (int k = 0; k < n; k++) r = {r[30:0], r[31]}; c = r[0]; end
      5'd12: begin r = a; for (int k = 0; k < n; k++) r = {r[0], r[31:1]}; c = r[31]; end
      5'd13: begin r = a; c = cin; for (int k = 0; k < n; k++) begin t = r[31]; r = {r[30:0], c}; c = t; end end
      5'd14: begin r = a; c = cin; for (int k = 0; k < n; k++) begin t = r[0];  r = {c, r[31:1]}; c = t; end end
      default: r = 32'd0;
    endcase
    f = {v, c, r[31], (r == 32'd0)};
  endfunction

  task automatic set_req(input int i, input bit vld, input bit [4:0] op, input bit [31:0] a,
                         input bit [31:0] b, input bit cin, input bit ucf);
    bus.req_valid[i]  = vld;
    bus.req_use_cf[i] = ucf;
    if (i == 0) begin bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; end
    else        begin bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".rsp_valid"},  32'(bus.rsp_valid),  32'(m_rv));
    chk({tag, ".rsp_id"},     32'(bus.rsp_id),     32'(m_id));
    chk({tag, ".rsp_result"}, bus.rsp_result,      m_res);
    chk({tag, ".rsp_flags"},  32'(bus.rsp_flags),  32'(m_flg));
    chk({tag, ".rsp_err"},    32'(bus.rsp_err),    32'(m_err));
    chk({tag, ".cf_q"},       32'(bus.cf_q),       32'(m_cf));
  endtask

  // One clock: check grant mid-cycle, advance the model, check registered outputs after the edge.
  task automatic cycle(input string tag);
    bit [1:0]  vv;
    bit        g, can, cin, e;
    bit [31:0] a, b, r;
    bit [4:0]  op;
    bit [3:0]  f;
    @(negedge clk);
    vv  = bus.req_valid;
    can = !m_rv || bus.rsp_ready;
    g   = (vv == 2'b11) ? m_rr : vv[1];
    m_ready = (can && vv != 2'b00) ? (2'b01 << g) : 2'b00;
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(m_ready));
    if (m_ready != 2'b00) begin
      a   = g ? bus.req1_a  : bus.req0_a;
      b   = g ? bus.req1_b  : bus.req0_b;
      op  = g ? bus.req1_op : bus.req0_op;
      cin = bus.req_use_cf[g] ? m_cf[g] : (g ? bus.req1_cin : bus.req0_cin);
      alu_ref(op, a, b, cin, r, f, e);
      m_rv = 1'b1; m_id = g; m_res = r; m_flg = f; m_err = e;
      if (!e) m_cf[g] = f[2];
      m_rr = ~g;
    end else if (bus.rsp_ready) begin
      m_rv = 1'b0;
    end
    @(posedge clk); #1;
    chk_outputs(tag);
  endtask

  task automatic model_reset();
    m_rv = 0; m_id = 0; m_err = 0; m_rr = 0; m_res = 0; m_flg = 0; m_cf = 2'b00; m_ready = 2'b00;
  endtask

  // Asserted asynchronously mid-cycle; checks that state clears without a clock edge.
  task automatic do_reset(input string tag);
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk({tag, ".req_ready_in_reset"}, 32'(bus.req_ready), 32'd0);
    chk_outputs(tag);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  bit [1:0] held;
  bit       cf0_save;

  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    set_req(1, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    #3;
    do_reset("reset");

    // RCL carry-out then reuse
    bus.rsp_ready = 1'b1;
    set_req(0, 1, 5'd13, 32'h8000_0000, 32'd1, 0, 0);
    cycle("rcl1");
    chk("rcl1.result_const", bus.rsp_result, 32'h0000_0000);
    chk("rcl1.carry_const",  32'(bus.rsp_flags[2]), 32'd1);
    chk("rcl1.cf0_const",    32'(bus.cf_q[0]), 32'd1);
    set_req(0, 1, 5'd13, 32'd0, 32'd1, 0, 1);
    cycle("rcl2");
    chk("rcl2.result_const", bus.rsp_result, 32'h0000_0001);
    chk("rcl2.cf0_const",    32'(bus.cf_q[0]), 32'd0);
    set_req(0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    cycle("drain");

    // Contention from reset
    do_reset("reset2");
    bus.rsp_ready = 1'b1;
    set_req(0, 1, 5'd11, 32'd1, 32'd1, 0, 0);
    set_req(1, 1, 5'd12, 32'd2, 32'd1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle("contend");
      chk("contend.id_const",     32'(bus.rsp_id), 32'(k % 2));
      chk("contend.result_const", bus.rsp_result, (k % 2) ? 32'h1 : 32'h2);
    end

    // Backpressure with both valid
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle("bp");
    bus.rsp_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release.id_const", 32'(bus.rsp_id), 32'd0);

    // Carry isolation on requester 1
    cf0_save = m_cf[0];
    set_req(0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    set_req(1, 1, 5'd14, 32'd1, 32'd1, 0, 0);
    cycle("rcr1");
    chk("rcr1.cf1_const", 32'(bus.cf_q[1]), 32'd1);
    chk("rcr1.cf0_kept",  32'(bus.cf_q[0]), 32'(cf0_save));
    set_req(1, 1, 5'd14, 32'd0, 32'd1, 0, 1);
    cycle("rcr2");
    chk("rcr2.result_const", bus.rsp_result, 32'h8000_0000);

    // Reset while a response is stalled and a carry is set
    set_req(1, 1, 5'd14, 32'd1, 32'd1, 0, 0);
    cycle("pre_rst");
    bus.rsp_ready = 1'b0;
    cycle("pre_rst_hold");
    do_reset("midrst");
    bus.rsp_ready = 1'b1;
    set_req(1, 1, 5'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0);
    cycle("post_rst_req1");
    chk("post_rst_req1.id_const", 32'(bus.rsp_id), 32'd1);
    do_reset("reset3");
    set_req(0, 1, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    set_req(1, 1, 5'd2, 32'd0, 32'd1, 0, 0);
    cycle("post_rst_both");
    chk("post_rst_both.id_const", 32'(bus.rsp_id), 32'd0);

    // Out-of-range opcode
    set_req(1, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    cf0_save = m_cf[0];
    set_req(0, 1, 5'd31, 32'd5, 32'd6, 1, 0);
    cycle("badop");
`ifdef ALU_ARB_OPCHK_EN
    chk("badop.err_const",    32'(bus.rsp_err), 32'd1);
    chk("badop.result_const", bus.rsp_result, 32'd0);
    chk("badop.cf0_kept",     32'(bus.cf_q[0]), 32'(cf0_save));
`else
    chk("badop.err_const",    32'(bus.rsp_err), 32'd0);
`endif

    // Randomized traffic; unaccepted requests keep their inputs stable
    held = 2'b00;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!held[i]) begin
          bit [4:0]  op;
          bit [31:0] a;
          op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
          case ($urandom_range(0, 3))
            0:       a = 32'h8000_0000;
            1:       a = 32'h0000_0001;
            default: a = $urandom;
          endcase
          set_req(i, ($urandom_range(0, 9) < 7), op, a, $urandom, 1'($urandom), 1'($urandom));
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
      held = bus.req_valid & ~m_ready;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational alu_advanced instance (A, B, Opcode[4:0], Cin -> Result[31:0], Flags[3:0] = {V,C,N,Z}) between two requesters.
- Each requester has its own saved carry flag, so rotate-through-carry (RCL/RCR) chains stay independent per requester.
- Arbitration is round-robin.
- Results go into a single registered response slot with a valid/ready handshake.
- Sits between the issue logic and the ALU datapath.

Parameters:
- LEGAL_OP_MAX, 5'd14, highest opcode the ALU executes (RCR = 5'b01110); used only when ALU_ARB_OPCHK_EN is defined.
- CF_RESET, 1'b0, reset value of both per-requester carry registers.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; transfer when valid & ready
- req0_a, req1_a  in  32  operand A
- req0_b, req1_b  in  32  operand B
- req0_op, req1_op  in  5  ALU opcode
- req0_cin, req1_cin  in  1  explicit carry-in
- req_use_cf  in  2  1 = Cin taken from that requester's saved carry instead of reqN_cin
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response
- rsp_result  out  32  registered Result
- rsp_flags  out  4  registered Flags {V,C,N,Z}
- rsp_err  out  1  illegal-opcode marker (0 when feature is compiled out)
- cf_q  out  2  saved carry per requester (debug/observe)

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0.
  - cf_q={CF_RESET,CF_RESET}.
  - Round-robin pointer rr=0 (requester 0 preferred).
  - req_ready=0 while in reset.
- can_accept = !rsp_valid | rsp_ready (combinational).
- Grant (combinational):
  - Only one requester valid: it is granted.
  - Both valid: requester rr is granted.
  - Neither valid: no grant.
  - req_ready[i] = can_accept & grant[i]. At most one bit is high. req_ready never depends on req_valid of the same requester beyond arbitration.
- ALU inputs are muxed from the granted requester. Cin = req_use_cf[g] ? cf_q[g] : reqg_cin.
- On a transfer at edge k:
  - rsp_* loaded from ALU outputs; rsp_id=g; rsp_valid=1 after edge k (latency 1 cycle).
  - cf_q[g] <= Flags[2].
  - rr <= ~g.
- No transfer but rsp_ready=1 with rsp_valid=1: rsp_valid <= 0. The other rsp_* fields hold their last values.
- Same-cycle drain and accept: the new response overwrites the slot and rsp_valid stays 1. Full throughput is one op per cycle.
- While rsp_valid=1 and rsp_ready=0: all rsp_* fields are stable, req_ready=00, cf_q is unchanged.
- rr changes only on a transfer. Nothing else alters arbitration order.
- The carry of requester i is updated only by requester i's transfers.
- Reset mid-operation: a pending response is discarded, cf_q is restored to CF_RESET, and no partial state survives.
- Requester inputs must be held stable while valid & !ready. The arbiter does not latch them.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - An opcode > LEGAL_OP_MAX is still accepted (handshake completes normally).
  - The response has rsp_err=1, rsp_result=0, rsp_flags=0.
  - cf_q[g] is unchanged; rr still advances.
- Undefined:
  - The opcode passes to the ALU unchecked.
  - rsp_err is tied 0.

Test Plan:
- RCL carry-out then reuse: req0 RCL A=0x80000000 B=1 cin=0 use_cf=0 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0x00000000, rsp_flags[2]=1, cf_q[0]=1. Then req0 RCL A=0 B=1 use_cf=1 -> rsp_result=0x00000001, cf_q[0]=0.
- Contention: both valid every cycle from reset, rsp_ready=1, req0 ROL A=1 B=1, req1 ROR A=2 B=1 -> grants 0,1,0,1. Results alternate 0x00000002 (id 0) and 0x00000001 (id 1), one response per cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles with both valid -> req_ready=00; rsp_result, rsp_id, rsp_flags unchanged. Release -> next grant follows rr.
- Carry isolation: req1 RCR A=1 B=1 cin=0 -> cf_q[1]=1, cf_q[0] untouched. Then req1 RCR A=0 B=1 use_cf=1 -> rsp_result=0x80000000.
- Reset mid-stream: assert rst_n=0 while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 and cf_q=00 immediately. After release, req1-only traffic is granted first.
- With ALU_ARB_OPCHK_EN: req0 op=5'b11111 -> req_ready[0]=1, rsp_err=1, rsp_result=0, cf_q[0] unchanged. Without the macro, rsp_err stays 0.
